board_streamer: RTL and testbench

Transmit end of the cell-stream protocol consumed by the board checker. Holds a 9x9 board loaded cell-by-cell from the recognition front end. On command, it streams all 81 cells in row-major order as one 11-bit word per cycle with a per-cell strobe. It then waits for the checker's done/valid pair and reports a latched pass/fail/timeout result.

---
 rtl/board_streamer.sv | 123 ++++++++++++
 tb/tb_board_streamer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_streamer.sv
// Transmit side of the cell-stream protocol: holds a 9x9 board, streams it
// row-major to the board checker, then latches the checker's verdict or a timeout.
module board_streamer #(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        wr_en,
   input  logic [6:0]  wr_addr,
   input  logic [3:0]  wr_digit,
   input  logic        go,
   output logic        busy,
   output logic        tx_start,
   output logic [10:0] tx_data,
   input  logic        rx_done,
   input  logic        rx_valid,
   output logic        result_strobe,
   output logic        result_ok,
   output logic        result_timeout,
   output logic [1:0]  dbg_state_o
);

   // Handshake: tx_start qualifies tx_data with no back-pressure (one cell per
   // cycle); rx_valid is meaningful only in a cycle where rx_done is high.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SEND = 2'd1,
      S_WAIT = 2'd2
   } state_e;

   state_e      state_q;
   logic [6:0]  idx_q, idx_d;
   logic [7:0]  tcnt_q, tcnt_d;
   logic        busy_q, tx_start_q, strobe_q, ok_q, timeout_q;
   logic [3:0]  cells_q [81];
   logic        idle;

   assign idle   = (state_q == S_IDLE);
   assign idx_d  = idx_q + 7'd1;
   assign tcnt_d = tcnt_q + 8'd1;

   function automatic logic [10:0] enc(input logic [3:0] d);
      logic [10:0] e;
      if (d >= 4'd1 && d <= 4'd9) e = {1'b0, 10'(10'd1 << d)};
      else                        e = 11'h400;
      return e;
   endfunction

   always_ff @(posedge clk) begin
      if (reset || (idle && clear)) begin
         for (int i = 0; i < 81; i++) cells_q[i] <= 4'd0;
      end else if (idle && wr_en && wr_addr <= 7'd80) begin
         cells_q[wr_addr] <= wr_digit;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         idx_q      <= 7'd0;
         tcnt_q     <= 8'd0;
         busy_q     <= 1'b0;
         tx_start_q <= 1'b0;
         strobe_q   <= 1'b0;
         ok_q       <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         strobe_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (go) begin
                  state_q    <= S_SEND;
                  idx_q      <= 7'd0;
                  busy_q     <= 1'b1;
                  tx_start_q <= 1'b1;
               end
            end
            S_SEND: begin
               if (idx_q == 7'd80) begin
                  state_q    <= S_WAIT;
                  tcnt_q     <= 8'd0;
                  tx_start_q <= 1'b0;
               end else begin
                  idx_q <= idx_d;
               end
            end
            S_WAIT: begin
               if (rx_done) begin
                  state_q   <= S_IDLE;
                  busy_q    <= 1'b0;
                  strobe_q  <= 1'b1;
                  ok_q      <= rx_valid;
                  timeout_q <= 1'b0;
               end else if (tcnt_q == 8'(TIMEOUT - 1)) begin
                  state_q   <= S_IDLE;
                  busy_q    <= 1'b0;
                  strobe_q  <= 1'b1;
                  ok_q      <= 1'b0;
                  timeout_q <= 1'b1;
               end else begin
                  tcnt_q <= tcnt_d;
               end
            end
            default: begin
               state_q    <= S_IDLE;
               busy_q     <= 1'b0;
               tx_start_q <= 1'b0;
            end
         endcase
      end
   end

   // Storage is read combinationally so a write taken with go is what streams.
   assign tx_data        = tx_start_q ? enc(cells_q[idx_q]) : 11'h000;
   assign tx_start       = tx_start_q;
   assign busy           = busy_q;
   assign result_strobe  = strobe_q;
   assign result_ok      = ok_q;
   assign result_timeout = timeout_q;
   assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_board_streamer.sv
// Randomized scoreboard bench for board_streamer: a board/legality model
// predicts every streamed word and every result; a monitor pops and compares.
module tb_board_streamer;

   localparam int TO = 15;

   logic        clk = 1'b0;
   logic        reset, clear, wr_en, go, rx_done, rx_valid;
   logic [6:0]  wr_addr;
   logic [3:0]  wr_digit;
   logic        busy, tx_start, result_strobe, result_ok, result_timeout;
   logic [10:0] tx_data;
   logic [1:0]  dbg_state;

   board_streamer #(.TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .clear(clear), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_digit(wr_digit), .go(go), .busy(busy), .tx_start(tx_start),
      .tx_data(tx_data), .rx_done(rx_done), .rx_valid(rx_valid),
      .result_strobe(result_strobe), .result_ok(result_ok),
      .result_timeout(result_timeout), .dbg_state_o(dbg_state)
   );

   always #5 clk = ~clk;

   typedef struct {int cyc; logic [10:0] data;} tx_exp_t;
   typedef struct {int cyc; bit ok; bit to;} res_exp_t;

   tx_exp_t     exp_tx_q[$];
   res_exp_t    exp_res_q[$];
   int          cyc = 0;
   int          go_cyc = 0;
   int          errors = 0;
   int          checks = 0;
   int          model[81];
   logic [10:0] cap[81];
   bit          lat_ok = 0, lat_to = 0;

   always @(posedge clk) cyc = cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [10:0] enc_model(input int d);
      if (d >= 1 && d <= 9) return 11'h001 << d;
      return 11'h400;
   endfunction

   function automatic int dec_word(input logic [10:0] w);
      for (int d = 1; d <= 9; d++) if (w == (11'h001 << d)) return d;
      return 0;
   endfunction

   // Legal board: no repeated digit 1..9 in any row, column or 3x3 box.
   function automatic bit legal(input int b[81]);
      bit [9:0] rm, cm, bm;
      int d;
      for (int u = 0; u < 9; u++) begin
         rm = '0; cm = '0; bm = '0;
         for (int j = 0; j < 9; j++) begin
            d = b[u*9 + j];
            if (d >= 1 && d <= 9) begin if (rm[d]) return 0; rm[d] = 1'b1; end
            d = b[j*9 + u];
            if (d >= 1 && d <= 9) begin if (cm[d]) return 0; cm[d] = 1'b1; end
            d = b[((u/3)*3 + j/3)*9 + (u%3)*3 + j%3];
            if (d >= 1 && d <= 9) begin if (bm[d]) return 0; bm[d] = 1'b1; end
         end
      end
      return 1;
   endfunction

   always @(negedge clk) begin
      tx_exp_t  et;
      res_exp_t er;
      int       n;
      if (tx_start) begin
         n = cyc - go_cyc - 1;
         if (n >= 0 && n < 81) cap[n] = tx_data;
         if (exp_tx_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_strobe: tx_start=1 data=%0h, none expected (cycle %0d)", tx_data, cyc);
         end else begin
            et = exp_tx_q.pop_front();
            check("tx_data", tx_data, et.data);
            check("strobe_cycle", cyc, et.cyc);
            check("busy_in_send", busy, 1);
            check("held_result_ok", result_ok, lat_ok);
            check("held_result_timeout", result_timeout, lat_to);
         end
      end else begin
         check("tx_data_idle", tx_data, 0);
      end
      if (result_strobe) begin
         if (exp_res_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_result: result_strobe=1, none expected (cycle %0d)", cyc);
         end else begin
            er = exp_res_q.pop_front();
            check("result_ok", result_ok, er.ok);
            check("result_timeout", result_timeout, er.to);
            check("result_cycle", cyc, er.cyc);
            check("busy_at_result", busy, 0);
            lat_ok = er.ok;
            lat_to = er.to;
         end
      end
      if (reset) begin
         lat_ok = 0;
         lat_to = 0;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_until(input int t);
      while (cyc < t) step();
   endtask

   task automatic model_clear();
      for (int i = 0; i < 81; i++) model[i] = 0;
   endtask

   // One input cycle; idle says whether the DUT is expected to honour it.
   task automatic cycle_in(input bit clr, input bit we, input int addr, input int dig,
                           input bit g, input bit idle);
      clear = clr; wr_en = we; wr_addr = addr[6:0]; wr_digit = dig[3:0]; go = g;
      if (idle) begin
         if (clr) model_clear();
         else if (we && addr <= 80) model[addr] = dig;
         if (g) go_cyc = cyc;
      end
      step();
      clear = 0; wr_en = 0; go = 0;
   endtask

   // side: 0 plain, 1 rx_done pulse in SEND, 2 writes/go/clear in SEND, 3 reset mid-SEND
   task automatic run_txn(input int k, input bit chain, input int side, input bit clr,
                          input bit we, input int addr, input int dig);
      int strobe_cyc;
      bit timed_out;
      int tmp[81];
      cycle_in(clr, we, addr, dig, 1, 1);
      for (int n = 0; n < 81; n++) exp_tx_q.push_back('{cyc: go_cyc + 1 + n, data: enc_model(model[n])});
      timed_out  = (k < 0) || (k >= TO);
      strobe_cyc = timed_out ? go_cyc + 82 + TO : go_cyc + 83 + k;
      if (side == 3) begin
         wait_until(go_cyc + 40);
         reset = 1;
         step();
         exp_tx_q.delete();
         model_clear();
         check("reset_tx_start", tx_start, 0);
         check("reset_busy", busy, 0);
         reset = 0;
         return;
      end
      exp_res_q.push_back('{cyc: strobe_cyc, ok: timed_out ? 1'b0 : legal(model), to: timed_out});
      if (side == 1) begin
         wait_until(go_cyc + 20);
         rx_done = 1; rx_valid = 1;
         step();
         rx_done = 0; rx_valid = 0;
      end
      if (side == 2) begin
         wait_until(go_cyc + 10);
         cycle_in(0, 1, 2, 7, 1, 0);
         cycle_in(1, 0, 0, 0, 0, 0);
      end
      if (k >= 0) begin
         wait_until(go_cyc + 82 + k);
         for (int n = 0; n < 81; n++) tmp[n] = dec_word(cap[n]);
         rx_done = 1; rx_valid = legal(tmp);
         step();
         rx_done = 0; rx_valid = 0;
      end
      wait_until(strobe_cyc);
      if (!chain) step();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      bit prev_chain;
      reset = 1; clear = 0; wr_en = 0; wr_addr = 0; wr_digit = 0; go = 0;
      rx_done = 0; rx_valid = 0;
      model_clear();
      repeat (3) step();
      check("rst_busy", busy, 0);
      check("rst_tx_start", tx_start, 0);
      check("rst_tx_data", tx_data, 0);
      check("rst_result_strobe", result_strobe, 0);
      check("rst_result_ok", result_ok, 0);
      check("rst_result_timeout", result_timeout, 0);
      reset = 0;
      step();

      run_txn(0, 0, 0, 0, 0, 0, 0);

      cycle_in(0, 1, 0, 5, 0, 1);
      cycle_in(0, 1, 80, 9, 0, 1);
      cycle_in(0, 1, 40, 12, 0, 1);
      run_txn(3, 0, 0, 0, 0, 0, 0);

      cycle_in(0, 1, 0, 3, 0, 1);
      cycle_in(0, 1, 1, 3, 0, 1);
      run_txn(0, 0, 0, 0, 0, 0, 0);
      run_txn(0, 0, 0, 1, 0, 0, 0);

      cycle_in(0, 1, 30, 6, 0, 1);
      run_txn(-1, 0, 1, 0, 0, 0, 0);

      run_txn(2, 0, 2, 0, 0, 0, 0);
      cycle_in(0, 1, 81, 4, 0, 1);
      cycle_in(0, 1, 127, 8, 0, 1);
      run_txn(1, 1, 0, 0, 1, 9, 9);
      run_txn(TO - 1, 0, 0, 0, 0, 0, 0);

      cycle_in(0, 1, 10, 4, 0, 1);
      run_txn(0, 0, 3, 0, 0, 0, 0);
      repeat (20) step();
      run_txn(0, 0, 0, 0, 0, 0, 0);

      prev_chain = 0;
      for (int i = 0; i < 12; i++) begin
         int k;
         int r;
         bit ch;
         if (!prev_chain) begin
            r = $urandom_range(0, 5);
            for (int j = 0; j < r; j++)
               cycle_in($urandom_range(0, 11) == 0, 1, $urandom_range(0, 85),
                        $urandom_range(0, 15), 0, 1);
         end
         r = $urandom_range(0, 9);
         k = (r == 0) ? -1 : (r == 1) ? TO + 1 : int'($urandom_range(0, TO - 1));
         ch = (k >= 0) && (k < TO) && ($urandom_range(0, 2) == 0) && (i < 11);
         run_txn(k, ch, 0, $urandom_range(0, 9) == 0, $urandom_range(0, 1),
                 $urandom_range(0, 82), $urandom_range(0, 15));
         prev_chain = ch;
      end

      repeat (10) step();
      check("tx_queue_drained", exp_tx_q.size(), 0);
      check("result_queue_drained", exp_res_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
